// File: rtl/uart_word_receiver_pkg.sv
// Shared definitions for the UART word receiver: default bit period and
// byte-placement helper used when assembling 32-bit words.
`ifndef DEFAULT_BAUD
`define DEFAULT_BAUD 16
`endif

package uart_word_receiver_pkg;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LAST_BYTE = 2'd3;

  // Bytes 0..2 of a word are parked here; byte 3 completes the word directly.
  function automatic logic [23:0] place_byte(input logic [23:0] prefix,
                                             input byte_idx_t   idx,
                                             input logic [7:0]  data);
    logic [23:0] result;
    result = prefix;
    case (idx)
      2'd0:    result[23:16] = data;
      2'd1:    result[15:8]  = data;
      default: result[7:0]   = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_word_receiver_rx.sv
// Byte-level 8N1 receiver: input synchronizer, bit-timing FSM and shift
// register. Emits one-cycle pulses for accepted bytes and framing errors.
module uart_rx #(
  parameter int BAUD = `DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       frame_err
);

  localparam int                CNT_W     = $clog2(BAUD);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(BAUD / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BAUD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t           r_state, w_state_next;
  logic             r_rx_meta, r_rx_sync;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next;
  logic [7:0]       r_shift, w_shift_next;
  logic             w_byte_ok, w_frame_bad;

  // Synchronizer resets high so a reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_byte_ok      = 1'b0;
    w_frame_bad    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_sync) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
        end
      end
      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = r_rx_sync ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next     = '0;
          w_shift_next   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_next = '0;
          if (r_rx_sync) begin
            w_byte_ok    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_bad  = 1'b1;
            w_state_next = S_RECOVER;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_RECOVER: begin
        if (r_rx_sync) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Pulses are issued in the stop-sample cycle so the word can load one clock later.
  assign rdata       = r_shift;
  assign rdata_valid = w_byte_ok;
  assign frame_err   = w_frame_bad;

endmodule

// File: rtl/uart_word_receiver.sv
// Assembles four UART bytes MSB-first into a 32-bit word with a valid/ready
// handshake, plus sticky framing-error and overrun flags.
module uart_word_receiver
  import uart_word_receiver_pkg::*;
#(
  parameter int BAUD = `DEFAULT_BAUD
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx,
  output logic [31:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        ferr,
  output logic        overrun,
  input  logic        err_clr
);

  logic [7:0]  w_rdata;
  logic        w_rdata_valid;
  logic        w_frame_err;
  logic        w_word_done, w_load, w_drop;

  byte_idx_t   r_byte_idx;
  logic [23:0] r_partial;
  logic [31:0] r_word;
  logic        r_word_valid, r_ferr, r_overrun;

  uart_rx #(.BAUD(BAUD)) u_rx (
    .clk         (clk),
    .rstn        (rstn),
    .rx          (rx),
    .rdata       (w_rdata),
    .rdata_valid (w_rdata_valid),
    .frame_err   (w_frame_err)
  );

  assign w_word_done = w_rdata_valid && (r_byte_idx == LAST_BYTE);
  assign w_load      = w_word_done && (!r_word_valid || word_ready);
  assign w_drop      = w_word_done && !w_load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_idx   <= '0;
      r_partial    <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_ferr       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // Rewinding the index is enough to discard a partial word.
      if (w_frame_err) begin
        r_byte_idx <= '0;
      end else if (w_rdata_valid) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx != LAST_BYTE)
          r_partial <= place_byte(r_partial, r_byte_idx, w_rdata);
      end

      if (w_load) begin
        r_word       <= {r_partial, w_rdata};
        r_word_valid <= 1'b1;
      end else if (r_word_valid && word_ready) begin
        r_word_valid <= 1'b0;
      end

      if (w_frame_err)  r_ferr <= 1'b1;
      else if (err_clr) r_ferr <= 1'b0;

      if (w_drop)       r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
    end
  end

  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign ferr       = r_ferr;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver: serial stimulus, inline comparisons.
module tb_uart_word_receiver;

  localparam int BAUD = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx = 1'b1;
  logic        word_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] word;
  logic        word_valid, ferr, overrun;

  int          checks = 0;
  int          failures = 0;
  int          hs_count = 0;
  logic [31:0] hs_word = '0;

  uart_word_receiver #(.BAUD(BAUD)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .ferr       (ferr),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn && word_valid && word_ready) begin
      hs_count = hs_count + 1;
      hs_word  = word;
      $display("handshake word=%08h", word);
    end
  end

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BAUD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk);
    $display("sent byte %02h stop=%0b", b, stop);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (word !== 32'h0) begin failures++; $display("FAIL reset_word got=%08h exp=00000000", word); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    rstn = 1'b1;
    idle_bits(1);
  endtask

  task automatic test_single_word();
    int c0;
    word_ready = 1'b1;
    c0 = hs_count;
    send_word(32'ha14e28c5);
    idle_bits(2);
    checks++; if (hs_count - c0 !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", hs_count - c0); end
    checks++; if (hs_word !== 32'ha14e28c5) begin failures++; $display("FAIL single_word got=%08h exp=a14e28c5", hs_word); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", word_valid); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL single_ferr got=%b exp=0", ferr); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL single_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_glitch();
    int c0;
    c0 = hs_count;
    rx = 1'b0;
    repeat (BAUD / 4) @(negedge clk);
    idle_bits(3);
    checks++; if (hs_count !== c0) begin failures++; $display("FAIL glitch_noword got=%0d exp=%0d", hs_count, c0); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL glitch_ferr got=%b exp=0", ferr); end
    send_word(32'h0badf00d);
    idle_bits(2);
    checks++; if (hs_count - c0 !== 1) begin failures++; $display("FAIL glitch_after_count got=%0d exp=1", hs_count - c0); end
    checks++; if (hs_word !== 32'h0badf00d) begin failures++; $display("FAIL glitch_after_word got=%08h exp=0badf00d", hs_word); end
  endtask

  task automatic test_framing();
    int c0;
    c0 = hs_count;
    send_byte(8'haa, 1'b1);
    send_byte(8'hbb, 1'b1);
    send_byte(8'hcc, 1'b0);
    rx = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    idle_bits(2);
    checks++; if (ferr !== 1'b1) begin failures++; $display("FAIL frame_ferr got=%b exp=1", ferr); end
    checks++; if (hs_count !== c0) begin failures++; $display("FAIL frame_noword got=%0d exp=%0d", hs_count, c0); end
    send_word(32'h12345678);
    idle_bits(2);
    checks++; if (hs_count - c0 !== 1) begin failures++; $display("FAIL frame_after_count got=%0d exp=1", hs_count - c0); end
    checks++; if (hs_word !== 32'h12345678) begin failures++; $display("FAIL frame_after_word got=%08h exp=12345678", hs_word); end
    checks++; if (ferr !== 1'b1) begin failures++; $display("FAIL frame_sticky got=%b exp=1", ferr); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL frame_clr got=%b exp=0", ferr); end
  endtask

  task automatic test_overrun();
    word_ready = 1'b0;
    send_word(32'ha14e28c5);
    send_word(32'h00000001);
    idle_bits(1);
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", word_valid); end
    checks++; if (word !== 32'ha14e28c5) begin failures++; $display("FAIL ovr_word got=%08h exp=a14e28c5", word); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL ovr_consume got=%b exp=0", word_valid); end
    checks++; if (word !== 32'ha14e28c5) begin failures++; $display("FAIL ovr_word_kept got=%08h exp=a14e28c5", word); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
  endtask

  task automatic test_clr_collision();
    bit hit;
    word_ready = 1'b0;
    send_word(32'h11111111);
    hit = 1'b0;
    fork
      send_word(32'h22222222);
      begin
        int n;
        n = 0;
        for (int t = 0; t < 60 * BAUD && !hit; t++) begin
          @(negedge clk);
          if (dut.w_rdata_valid) begin
            n++;
            if (n == 4) begin
              err_clr = 1'b1;
              hit = 1'b1;
            end
          end
        end
        @(negedge clk);
        err_clr = 1'b0;
      end
    join
    idle_bits(1);
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL collide_timeout got=%b exp=1", hit); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL collide_overrun got=%b exp=1", overrun); end
    checks++; if (word !== 32'h11111111) begin failures++; $display("FAIL collide_word got=%08h exp=11111111", word); end
  endtask

  task automatic test_reset_midframe();
    int c0;
    word_ready = 1'b1;
    @(negedge clk);
    send_byte(8'hde, 1'b1);
    send_byte(8'had, 1'b1);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BAUD) @(negedge clk);
    end
    rstn = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (word !== 32'h0) begin failures++; $display("FAIL midrst_word got=%08h exp=00000000", word); end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", word_valid); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL midrst_ferr got=%b exp=0", ferr); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun got=%b exp=0", overrun); end
    rstn = 1'b1;
    idle_bits(1);
    c0 = hs_count;
    send_word(32'hdeadbeef);
    idle_bits(2);
    checks++; if (hs_count - c0 !== 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", hs_count - c0); end
    checks++; if (hs_word !== 32'hdeadbeef) begin failures++; $display("FAIL midrst_after_word got=%08h exp=deadbeef", hs_word); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL midrst_after_ferr got=%b exp=0", ferr); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_glitch();
    test_framing();
    test_overrun();
    test_clr_collision();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_receiver.md
UART_WORD_RECEIVER -- requirements
Module: uart_word_receiver

Interface
REQ-001 SHALL have parameter BAUD, default `DEFAULT_BAUD (from include.vh): clock cycles per UART bit, legal range >= 4.
REQ-002 SHALL have port clk, input, 1: single clock for all state.
REQ-003 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port rx, input, 1: asynchronous serial line, 8N1, idle high.
REQ-005 SHALL have port word, output, 32: assembled word.
REQ-006 SHALL have port word_valid, output, 1: word holds an unconsumed value.
REQ-007 SHALL have port word_ready, input, 1: consumer accepts word this cycle.
REQ-008 SHALL have port ferr, output, 1: sticky framing-error flag.
REQ-009 SHALL have port overrun, output, 1: sticky dropped-word flag.
REQ-010 SHALL have port err_clr, input, 1: clears ferr and overrun.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, RECOVER.
REQ-013 IDLE -> START on synchronized rx == 0, with the bit counter cleared.
REQ-014 START SHALL sample at count BAUD/2-1: rx == 0 -> DATA (counter and bit index cleared); rx == 1 -> IDLE as a glitch, with no flag.
REQ-015 DATA SHALL sample every BAUD cycles, shifting bits in LSB first; after the 8th bit it enters STOP.
REQ-016 STOP SHALL sample after BAUD cycles:
- rx == 1: byte accepted, go to IDLE.
- rx == 0: ferr set, byte and any partial word discarded (byte index -> 0), go to RECOVER.
REQ-017 RECOVER -> IDLE only once synchronized rx == 1.
REQ-018 Accepted bytes SHALL fill the word MSB-first: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0]; the 2-bit byte index wraps 3 -> 0.
REQ-019 On the 4th accepted byte, when word_valid == 0 or word_valid & word_ready, word SHALL load and word_valid SHALL be 1 the next cycle (latency 1 clk after the final stop sample).
REQ-020 Otherwise the new word SHALL be dropped, the held word kept unchanged, and overrun set.
REQ-021 word_valid & word_ready with no simultaneous load SHALL clear word_valid the next cycle; word keeps its last value.
REQ-022 err_clr SHALL clear ferr and overrun the next cycle; a simultaneous set event wins.
REQ-023 The receiver SHALL accept back-to-back frames with zero idle bits between the stop bit and the next start bit.

Reset
REQ-024 rstn low SHALL force: word = 0, word_valid = 0, ferr = 0, overrun = 0, state = IDLE, counters and byte index = 0, synchronizer flops = 1 (no false start).
REQ-025 Reset mid-frame SHALL discard the partial byte and the partial word; reception resumes at the next start bit after release.

Structure
REQ-026 `DEFAULT_BAUD SHALL stay in the shared include.vh; state encodings SHALL be module-local constants.
REQ-027 The byte-level receiver (synchronizer, FSM, bit counter, shift register) SHALL be a sub-module uart_rx with outputs rdata[8], rdata_valid (1-cycle pulse) and frame_err (1-cycle pulse); word assembly, handshake and flags SHALL reside in uart_word_receiver.
REQ-028 Counter width SHALL be $clog2(BAUD).

Verification
REQ-029 uart_input_generate (SEND_DATA = 32'ha14e28c5, same BAUD) drives rx, word_ready = 1 -> exactly one word_valid pulse, word = 32'ha14e28c5, ferr = 0, overrun = 0.
REQ-030 rx low for BAUD/4 cycles then high -> no rdata_valid, state back in IDLE, ferr = 0.
REQ-031 Byte 2 sent with stop bit = 0, line then held low for 3*BAUD, then clean bytes 12 34 56 78 -> ferr = 1, no word for the aborted frame, then word = 32'h12345678.
REQ-032 Words ha14e28c5 then h00000001 sent with word_ready = 0 -> word stays ha14e28c5 and overrun = 1; a word_ready pulse -> word_valid = 0 next cycle; err_clr -> overrun = 0.
REQ-033 rstn pulsed during byte 3 -> all outputs 0 during reset; then word 32'hdeadbeef received intact.
REQ-034 err_clr asserted in the same cycle as an overrun event -> overrun = 1 afterwards.
